// File: rtl/traffic_ctrl_n.sv
// N-approach traffic-light controller: round-robin service of congested roads with
// sensor-weighted green time, optional all-red clearance and emergency pre-emption.
module traffic_ctrl_n #(
    parameter int unsigned N_ROADS = 4,
    parameter int unsigned SENS    = 2,
    parameter int unsigned SLOT    = 15,
    parameter int unsigned YELLOW  = 3,
    parameter int unsigned ALL_RED = 0
) (
    input  logic                      clk_i,
    input  logic                      rst_ni,
    input  logic [N_ROADS*SENS-1:0]   sensors_i,
    input  logic [N_ROADS-1:0]        emerg_i,
    output logic [3*N_ROADS-1:0]      lights_o,
    output logic [2:0]                cur_road_o,
    output logic [2:0]                phase_o
);

    localparam int unsigned GreenMax = SLOT * SENS;
    localparam int unsigned MaxA     = (GreenMax > YELLOW) ? GreenMax : YELLOW;
    localparam int unsigned MaxT     = (MaxA > ALL_RED) ? MaxA : ALL_RED;
    localparam int unsigned TW       = $clog2(MaxT + 1);

    typedef enum logic [2:0] {
        StHold   = 3'd0,
        StGreen  = 3'd1,
        StYellow = 3'd2,
        StAllRed = 3'd3,
        StEmerg  = 3'd4
    } state_e;

    state_e                 state_q, state_d;
    logic [2:0]             cur_q, cur_d;
    logic [2:0]             next_q, next_d;
    logic [TW-1:0]          timer_q, timer_d;
    logic [3*N_ROADS-1:0]   lights_q;

    logic [7:0]             cong;
    logic [7:0][TW-1:0]     load_val;
    logic                   emerg_any;
    logic [2:0]             emerg_idx;
    logic                   hold_found, exp_found;
    logic [2:0]             hold_idx, exp_idx;
    logic [2:0]             next_eff;

    function automatic logic [TW-1:0] green_load(input logic [SENS-1:0] s);
        int unsigned c;
        c = 0;
        for (int i = 0; i < int'(SENS); i++) begin
            if (s[i]) c++;
        end
        if (c == 0) c = 1;
        return TW'(SLOT * c);
    endfunction

    function automatic logic [2:0] wrap(input int v);
        int w;
        w = (v >= int'(N_ROADS)) ? v - int'(N_ROADS) : v;
        return 3'(w);
    endfunction

    function automatic logic [3*N_ROADS-1:0] lights_for(input state_e s, input logic [2:0] c);
        logic [3*N_ROADS-1:0] l;
        for (int r = 0; r < int'(N_ROADS); r++) begin
            l[3*r +: 3] = 3'b100;
            if (s != StAllRed && int'(c) == r) begin
                l[3*r +: 3] = (s == StYellow) ? 3'b010 : 3'b001;
            end
        end
        return l;
    endfunction

    always_comb begin
        cong       = '0;
        load_val   = '0;
        emerg_any  = |emerg_i;
        emerg_idx  = '0;
        hold_found = 1'b0;
        hold_idx   = cur_q;
        exp_found  = 1'b0;
        exp_idx    = cur_q;

        for (int r = 0; r < 8; r++) begin
            load_val[r] = TW'(SLOT);
        end
        for (int r = 0; r < int'(N_ROADS); r++) begin
            cong[r]     = |sensors_i[r*SENS +: SENS];
            load_val[r] = green_load(sensors_i[r*SENS +: SENS]);
        end
        for (int r = int'(N_ROADS) - 1; r >= 0; r--) begin
            if (emerg_i[r]) emerg_idx = 3'(r);
        end

        // HOLD searches from cur; expiry searches from cur+1 with cur last
        for (int k = 0; k < int'(N_ROADS); k++) begin
            if (!hold_found && cong[wrap(int'(cur_q) + k)]) begin
                hold_found = 1'b1;
                hold_idx   = wrap(int'(cur_q) + k);
            end
        end
        for (int k = 1; k <= int'(N_ROADS); k++) begin
            if (!exp_found && cong[wrap(int'(cur_q) + k)]) begin
                exp_found = 1'b1;
                exp_idx   = wrap(int'(cur_q) + k);
            end
        end
        next_eff = emerg_any ? emerg_idx : next_q;

        state_d = state_q;
        cur_d   = cur_q;
        next_d  = next_q;
        timer_d = timer_q;

        unique case (state_q)
            StHold, StGreen, StEmerg: begin
                if (emerg_any) begin
                    if (emerg_idx == cur_q) begin
                        state_d = StEmerg;
                        timer_d = '0;
                    end else begin
                        next_d  = emerg_idx;
                        state_d = StYellow;
                        timer_d = TW'(YELLOW);
                    end
                end else if (state_q == StHold) begin
                    if (hold_found && hold_idx == cur_q) begin
                        state_d = StGreen;
                        timer_d = load_val[cur_q];
                    end else if (hold_found) begin
                        next_d  = hold_idx;
                        state_d = StYellow;
                        timer_d = TW'(YELLOW);
                    end
                end else if (state_q == StGreen && timer_q > TW'(1)) begin
                    timer_d = timer_q - TW'(1);
                end else if (exp_found) begin
                    // Green expiry, or emergency release
                    next_d  = exp_idx;
                    state_d = StYellow;
                    timer_d = TW'(YELLOW);
                end else begin
                    state_d = StHold;
                    timer_d = '0;
                end
            end
            StYellow, StAllRed: begin
                next_d = next_eff;
                if (timer_q > TW'(1)) begin
                    timer_d = timer_q - TW'(1);
                end else if (state_q == StYellow && ALL_RED != 0) begin
                    state_d = StAllRed;
                    timer_d = TW'(ALL_RED);
                end else begin
                    state_d = StGreen;
                    cur_d   = next_eff;
                    timer_d = load_val[next_eff];
                end
            end
            default: begin
                state_d = StHold;
                cur_d   = '0;
                next_d  = '0;
                timer_d = '0;
            end
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q  <= StHold;
            cur_q    <= '0;
            next_q   <= '0;
            timer_q  <= '0;
            lights_q <= lights_for(StHold, 3'd0);
        end else begin
            state_q  <= state_d;
            cur_q    <= cur_d;
            next_q   <= next_d;
            timer_q  <= timer_d;
            lights_q <= lights_for(state_d, cur_d);
        end
    end

    assign lights_o   = lights_q;
    assign cur_road_o = cur_q;
    assign phase_o    = state_q;

endmodule

// File: tb/tb_traffic_ctrl_n.sv
// Directed bench for traffic_ctrl_n: table of timed checkpoints plus hand-written
// sequences for all-red clearance and asynchronous reset mid-yellow.
module tb_traffic_ctrl_n;

    localparam logic [2:0] PH_HOLD = 3'd0;
    localparam logic [2:0] PH_GRN  = 3'd1;
    localparam logic [2:0] PH_YEL  = 3'd2;
    localparam logic [2:0] PH_AR   = 3'd3;
    localparam logic [2:0] PH_EM   = 3'd4;

    localparam logic [11:0] G0 = 12'h921;
    localparam logic [11:0] Y0 = 12'h922;
    localparam logic [11:0] G1 = 12'h90C;
    localparam logic [11:0] Y1 = 12'h914;
    localparam logic [11:0] G2 = 12'h864;
    localparam logic [11:0] Y2 = 12'h8A4;
    localparam logic [11:0] G3 = 12'h324;
    localparam logic [11:0] Y3 = 12'h524;
    localparam logic [11:0] AR = 12'h924;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [7:0]  sensors = '0;
    logic [3:0]  emerg = '0;
    logic [11:0] lights1, lights2;
    logic [2:0]  cur1, cur2, ph1, ph2;
    bit          mon_en = 1'b0;
    int          total = 0;
    int          bad = 0;

    always #5 clk = ~clk;

    traffic_ctrl_n dut (
        .clk_i      (clk),
        .rst_ni     (rst_n),
        .sensors_i  (sensors),
        .emerg_i    (emerg),
        .lights_o   (lights1),
        .cur_road_o (cur1),
        .phase_o    (ph1)
    );

    traffic_ctrl_n #(.ALL_RED(2)) dut_ar (
        .clk_i      (clk),
        .rst_ni     (rst_n),
        .sensors_i  (sensors),
        .emerg_i    (emerg),
        .lights_o   (lights2),
        .cur_road_o (cur2),
        .phase_o    (ph2)
    );

    typedef struct {
        bit          rst;
        logic [7:0]  sens;
        logic [3:0]  em;
        int          nwait;
        logic [2:0]  ph;
        logic [2:0]  cur;
        logic [11:0] lt;
    } vec_t;

    vec_t vecs[$];

    task automatic add(input bit r, input logic [7:0] s, input logic [3:0] e, input int n,
                       input logic [2:0] p, input logic [2:0] c, input logic [11:0] l);
        vec_t v;
        v.rst = r; v.sens = s; v.em = e; v.nwait = n; v.ph = p; v.cur = c; v.lt = l;
        vecs.push_back(v);
    endtask

    task automatic chk(input string name, input logic [11:0] got, input logic [11:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h", name, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        step();
        rst_n = 1'b1;
    endtask

    function automatic bit lights_ok(input logic [11:0] l);
        int nr;
        logic [2:0] f;
        nr = 0;
        if ($isunknown(l)) return 1'b0;
        for (int r = 0; r < 4; r++) begin
            f = l[3*r +: 3];
            if (f != 3'b001 && f != 3'b010 && f != 3'b100) return 1'b0;
            if (f != 3'b100) nr++;
        end
        return nr <= 1;
    endfunction

    // Every cycle: each lamp one-hot, at most one road non-red, no X anywhere
    always @(negedge clk) begin
        if (mon_en) begin
            chk("onehot dut", {11'd0, lights_ok(lights1)}, 12'd1);
            chk("onehot dut_ar", {11'd0, lights_ok(lights2)}, 12'd1);
            chk("no_x", {11'd0, $isunknown({cur1, ph1, cur2, ph2})}, 12'd0);
        end
    end

    initial begin
        int run;
        int runs;

        // 1: two congested roads alternate, 15-cycle greens
        add(1, 8'h0A, 4'h0,  0, PH_HOLD, 3'd0, G0);
        add(0, 8'h0A, 4'h0,  1, PH_GRN,  3'd0, G0);
        add(0, 8'h0A, 4'h0, 14, PH_GRN,  3'd0, G0);
        add(0, 8'h0A, 4'h0,  1, PH_YEL,  3'd0, Y0);
        add(0, 8'h0A, 4'h0,  2, PH_YEL,  3'd0, Y0);
        add(0, 8'h0A, 4'h0,  1, PH_GRN,  3'd1, G1);
        add(0, 8'h0A, 4'h0, 14, PH_GRN,  3'd1, G1);
        add(0, 8'h0A, 4'h0,  1, PH_YEL,  3'd1, Y1);
        add(0, 8'h0A, 4'h0,  3, PH_GRN,  3'd0, G0);
        // 2: all sensors, 30-cycle greens in order 0,1,2,3,0
        add(1, 8'hFF, 4'h0,  0, PH_HOLD, 3'd0, G0);
        add(0, 8'hFF, 4'h0,  1, PH_GRN,  3'd0, G0);
        add(0, 8'hFF, 4'h0, 29, PH_GRN,  3'd0, G0);
        add(0, 8'hFF, 4'h0,  1, PH_YEL,  3'd0, Y0);
        add(0, 8'hFF, 4'h0,  2, PH_YEL,  3'd0, Y0);
        add(0, 8'hFF, 4'h0,  1, PH_GRN,  3'd1, G1);
        add(0, 8'hFF, 4'h0, 29, PH_GRN,  3'd1, G1);
        add(0, 8'hFF, 4'h0,  1, PH_YEL,  3'd1, Y1);
        add(0, 8'hFF, 4'h0,  3, PH_GRN,  3'd2, G2);
        add(0, 8'hFF, 4'h0, 29, PH_GRN,  3'd2, G2);
        add(0, 8'hFF, 4'h0,  1, PH_YEL,  3'd2, Y2);
        add(0, 8'hFF, 4'h0,  3, PH_GRN,  3'd3, G3);
        add(0, 8'hFF, 4'h0, 29, PH_GRN,  3'd3, G3);
        add(0, 8'hFF, 4'h0,  1, PH_YEL,  3'd3, Y3);
        add(0, 8'hFF, 4'h0,  3, PH_GRN,  3'd0, G0);
        // 3: roads 1,2 idle are skipped; then road0 alone repeats with yellow
        add(1, 8'h41, 4'h0, 15, PH_GRN,  3'd0, G0);
        add(0, 8'h41, 4'h0,  1, PH_YEL,  3'd0, Y0);
        add(0, 8'h41, 4'h0,  3, PH_GRN,  3'd3, G3);
        add(0, 8'h41, 4'h0, 14, PH_GRN,  3'd3, G3);
        add(0, 8'h41, 4'h0,  1, PH_YEL,  3'd3, Y3);
        add(0, 8'h41, 4'h0,  3, PH_GRN,  3'd0, G0);
        add(0, 8'h01, 4'h0, 14, PH_GRN,  3'd0, G0);
        add(0, 8'h01, 4'h0,  1, PH_YEL,  3'd0, Y0);
        add(0, 8'h01, 4'h0,  2, PH_YEL,  3'd0, Y0);
        add(0, 8'h01, 4'h0,  1, PH_GRN,  3'd0, G0);
        add(0, 8'h01, 4'h0, 14, PH_GRN,  3'd0, G0);
        add(0, 8'h01, 4'h0,  1, PH_YEL,  3'd0, Y0);
        // 4: sensors drop during green -> HOLD; road3 later wakes it
        add(1, 8'h01, 4'h0,  1, PH_GRN,  3'd0, G0);
        add(0, 8'h00, 4'h0, 14, PH_GRN,  3'd0, G0);
        add(0, 8'h00, 4'h0,  1, PH_HOLD, 3'd0, G0);
        add(0, 8'h00, 4'h0, 64, PH_HOLD, 3'd0, G0);
        add(0, 8'h40, 4'h0,  1, PH_YEL,  3'd0, Y0);
        add(0, 8'h40, 4'h0,  2, PH_YEL,  3'd0, Y0);
        add(0, 8'h40, 4'h0,  1, PH_GRN,  3'd3, G3);
        // 6: emergency on road2 truncates road0 green, release hands over to road3
        add(1, 8'hFF, 4'h0,  5, PH_GRN,  3'd0, G0);
        add(0, 8'hFF, 4'h4,  1, PH_YEL,  3'd0, Y0);
        add(0, 8'hFF, 4'h4,  2, PH_YEL,  3'd0, Y0);
        add(0, 8'hFF, 4'h4,  1, PH_GRN,  3'd2, G2);
        add(0, 8'hFF, 4'h4,  1, PH_EM,   3'd2, G2);
        add(0, 8'hFF, 4'h4, 50, PH_EM,   3'd2, G2);
        add(0, 8'hFF, 4'h0,  1, PH_YEL,  3'd2, Y2);
        add(0, 8'hFF, 4'h0,  2, PH_YEL,  3'd2, Y2);
        add(0, 8'hFF, 4'h0,  1, PH_GRN,  3'd3, G3);
        // Emergency during yellow overrides next; lower index pre-empts EMERG
        add(1, 8'hFF, 4'h0, 31, PH_YEL,  3'd0, Y0);
        add(0, 8'hFF, 4'h8,  3, PH_GRN,  3'd3, G3);
        add(0, 8'hFF, 4'h8,  1, PH_EM,   3'd3, G3);
        add(0, 8'hFF, 4'h9,  1, PH_YEL,  3'd3, Y3);
        add(0, 8'hFF, 4'h9,  3, PH_GRN,  3'd0, G0);
        add(0, 8'hFF, 4'h9,  1, PH_EM,   3'd0, G0);

        step();
        chk("reset lights", lights1, G0);
        chk("reset phase", {9'd0, ph1}, {9'd0, PH_HOLD});
        mon_en = 1'b1;

        foreach (vecs[i]) begin
            sensors = vecs[i].sens;
            emerg   = vecs[i].em;
            if (vecs[i].rst) do_reset();
            repeat (vecs[i].nwait) step();
            chk($sformatf("v%0d phase", i), {9'd0, ph1}, {9'd0, vecs[i].ph});
            chk($sformatf("v%0d cur", i), {9'd0, cur1}, {9'd0, vecs[i].cur});
            chk($sformatf("v%0d lights", i), lights1, vecs[i].lt);
        end

        // 5: ALL_RED=2 instance shows exactly two all-red cycles per handover
        sensors = 8'hFF;
        emerg   = 4'h0;
        do_reset();
        run  = 0;
        runs = 0;
        for (int c = 1; c <= 145; c++) begin
            step();
            if (ph2 == PH_AR) begin
                run++;
                chk($sformatf("allred lamps c%0d", c), lights2, AR);
            end else if (run != 0) begin
                chk($sformatf("allred len c%0d", c), 12'(run), 12'd2);
                runs++;
                run = 0;
            end
            if (c == 33) chk("ar yellow end", {9'd0, ph2}, {9'd0, PH_YEL});
            if (c == 36) begin
                chk("ar green1 phase", {9'd0, ph2}, {9'd0, PH_GRN});
                chk("ar green1 lights", lights2, G1);
            end
        end
        chk("allred runs", 12'(runs), 12'd4);

        // Asynchronous reset in the middle of road1's yellow
        do_reset();
        repeat (65) step();
        chk("pre-rst phase", {9'd0, ph1}, {9'd0, PH_YEL});
        chk("pre-rst lights", lights1, Y1);
        rst_n = 1'b0;
        #1;
        chk("async rst phase", {9'd0, ph1}, {9'd0, PH_HOLD});
        chk("async rst cur", {9'd0, cur1}, 12'd0);
        chk("async rst lights", lights1, G0);
        chk("async rst lights ar", lights2, G0);
        step();
        rst_n = 1'b1;
        step();

        mon_en = 1'b0;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
